// File: rtl/multi_channel_stable_capture.sv
// Multi-channel CDC capture: each channel commits a value only after it has been stable for STABLE_COUNT cycles.
// Define MULTI_CHANNEL_STABLE_CAPTURE_REJECT_CNT_EN to enable the saturating reject_count instability counter.
module multi_channel_stable_capture #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CH       = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_COUNT = 3
) (
    input  logic                         a_clk,
    input  logic                         a_resetn,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic                         freeze,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]            out_upd,
    output logic [15:0]                  reject_count
);

    localparam int CW = $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0] SC = CW'(STABLE_COUNT);

    // Asynchronous assertion, synchronous release of the internal reset.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) rst_sync <= '0;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

`ifdef MULTI_CHANNEL_STABLE_CAPTURE_REJECT_CNT_EN
    logic [NUM_CH-1:0] unstable;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SYNC_STAGES*DATA_WIDTH-1:0] sync_q;
        logic [DATA_WIDTH-1:0]             prev_q;
        logic [DATA_WIDTH-1:0]             out_q;
        logic                              upd_q;
        logic [CW-1:0]                     cnt_q;
        logic [DATA_WIDTH-1:0]             cand;
        logic                              eq;
        logic                              commit;

        assign cand   = sync_q[SYNC_STAGES*DATA_WIDTH-1 -: DATA_WIDTH];
        assign eq     = (cand == prev_q);
        assign commit = (cnt_q == SC) && eq && !freeze && (cand != out_q);

        always_ff @(posedge a_clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                prev_q <= '0;
                cnt_q  <= '0;
                out_q  <= '0;
                upd_q  <= 1'b0;
            end else begin
                // Stage 0 sits in the low slice; the chain shifts toward the MSBs.
                sync_q <= {sync_q[(SYNC_STAGES-1)*DATA_WIDTH-1:0],
                           in_data[c*DATA_WIDTH +: DATA_WIDTH]};
                prev_q <= cand;
                if (!eq)             cnt_q <= '0;
                else if (cnt_q < SC) cnt_q <= cnt_q + 1'b1;
                upd_q <= commit;
                if (commit) out_q <= cand;
            end
        end

        assign out_data[c*DATA_WIDTH +: DATA_WIDTH] = out_q;
        assign out_upd[c] = upd_q;

`ifdef MULTI_CHANNEL_STABLE_CAPTURE_REJECT_CNT_EN
        assign unstable[c] = !eq && (cnt_q != '0);
`endif
    end

`ifdef MULTI_CHANNEL_STABLE_CAPTURE_REJECT_CNT_EN
    logic [15:0] rej_q;

    always_ff @(posedge a_clk or negedge rst_n) begin
        if (!rst_n)                            rej_q <= '0;
        else if (|unstable && rej_q != '1)     rej_q <= rej_q + 16'd1;
    end

    assign reject_count = rej_q;
`else
    assign reject_count = '0;
`endif

endmodule

// File: doc/multi_channel_stable_capture.md
MULTI_CHANNEL_STABLE_CAPTURE -- requirements
Module: multi_channel_stable_capture

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: bits per channel.
REQ-002 The block SHALL have parameter NUM_CH, default 4: independent channel count.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2 (legal values 2 to 4): synchroniser depth.
REQ-004 The block SHALL have parameter STABLE_COUNT, default 3 (legal values 1 to 255): consecutive equal samples required after the first match.
REQ-005 The block SHALL have port a_clk, input, 1 bit: sole clock, rising edge.
REQ-006 The block SHALL have port a_resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port in_data, input, NUM_CH*DATA_WIDTH bits: per-channel data driven from an unrelated domain; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port freeze, input, 1 bit, synchronous to a_clk: blocks commits.
REQ-009 The block SHALL have port out_data, output, NUM_CH*DATA_WIDTH bits: committed values, registered.
REQ-010 The block SHALL have port out_upd, output, NUM_CH bits: one-cycle commit pulse per channel, registered.
REQ-011 The block SHALL have port reject_count, output, 16 bits: count of instability events.

Function
REQ-012 Each channel SHALL have its own independent chain of SYNC_STAGES registers: s0 <= in_data, sk <= sk-1; cand is the last stage.
REQ-013 Each channel SHALL register prev <= cand every cycle; eq is defined as (cand == prev).
REQ-014 Each channel SHALL have a counter cnt of width clog2(STABLE_COUNT+1) that behaves as follows:
- if eq is 0, cnt <= 0;
- else if cnt < STABLE_COUNT, cnt <= cnt+1;
- else cnt holds (saturates).
REQ-015 A commit SHALL occur when cnt == STABLE_COUNT, eq == 1, freeze == 0 and cand != out_data[c]. On commit: out_data[c] <= cand and out_upd[c] <= 1 on the same edge.
REQ-016 out_upd[c] SHALL be 0 on every cycle without a commit.
REQ-017 Latency: when in_data[c] changes, is first sampled at edge T and stays constant, out_data[c] SHALL update at edge T+SYNC_STAGES+STABLE_COUNT+1. With defaults this is T+6.
REQ-018 If cand equals out_data[c] once stable, there SHALL be no commit and no pulse.
REQ-019 If freeze is high on a cycle where the commit condition is otherwise met, the block SHALL NOT commit and cnt SHALL stay saturated. The commit SHALL occur on the first edge with freeze low, provided eq still holds.
REQ-020 Any input change before cnt saturates SHALL restart qualification; partially stable values SHALL never reach out_data.
REQ-021 Channels SHALL be fully independent; simultaneous commits on several channels SHALL all take effect on the same edge.
REQ-022 An instability event SHALL be defined as a cycle where eq == 0 and cnt != 0 on a given channel. Multiple channels in one cycle SHALL count as one event.

Reset
REQ-023 While a_resetn is low, all synchroniser stages, prev, cnt, out_data, out_upd and reject_count SHALL be 0 asynchronously.
REQ-024 Reset deassertion SHALL take effect synchronously to a_clk through the team's standard reset path; the first qualification SHALL start from the all-zero state.
REQ-025 Reset asserted mid-qualification SHALL discard the pending value; no commit or pulse SHALL follow from it.

Configuration
REQ-026 When macro MULTI_CHANNEL_STABLE_CAPTURE_REJECT_CNT_EN is defined, reject_count SHALL increment by 1 per instability event and SHALL saturate at 16'hFFFF.
REQ-027 When the macro is undefined, reject_count SHALL be tied to 0, no counter logic SHALL be synthesised, and all other behaviour SHALL be identical.

Verification
REQ-028 Defaults: after reset, set channel 0 to 32'hDEADBEEF at edge T and hold. Required: out_data[31:0] = DEADBEEF at T+6, out_upd = 4'b0001 for exactly 1 cycle; other channels stay 0.
REQ-029 Toggle channel 1 between 32'h1 and 32'h2 every 3 cycles for 30 cycles. Required: no commit and out_upd[1] never asserted; with the macro defined, reject_count > 0.
REQ-030 Hold freeze high, then set channel 2 to 32'h55. Required: out_data unchanged after 20 cycles. Drop freeze. Required: commit and pulse on the next edge.
REQ-031 Change all 4 channels on the same edge to 32'hA0 to 32'hA3. Required: one edge with out_upd = 4'b1111 and all values correct.
REQ-032 Pulse a_resetn low for 1 cycle at T+3 of a pending change. Required: outputs 0 immediately and no pulse. Also: re-apply a value equal to out_data; required: no pulse.
REQ-033 Run SYNC_STAGES=3, STABLE_COUNT=1, DATA_WIDTH=8, NUM_CH=1. Required: latency of 5 edges.
